// File: rtl/hazard_flush_ctrl.sv
// Pipeline sequencing controller: memory freeze, load-use stall and taken-branch flush,
// with saturating stall/flush event counters for performance debug.
module hazard_flush_ctrl #(
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bl,
  input  logic             br,
  input  logic             beq,
  input  logic             beq_equal,
  input  logic [3:0]       ID_rs,
  input  logic [3:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic             EX_mem_read,
  input  logic [3:0]       EX_rd,
  input  logic             mem_busy,
  output logic             pc_write_en,
  output logic             IF_ID_write_en,
  output logic             IF_ID_sync_nop,
  output logic             ID_EX_nop,
  output logic [2:0]       IF_branch_select,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    FLUSH  = 2'b01,
    FREEZE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       FCNT_LOAD = 3'(BRANCH_PENALTY - 1);

  state_t           state_r, next_state_s;
  logic [2:0]       fcnt_r, fcnt_next_s;
  logic             ctx_r, ctx_next_s;
  logic [CNT_W-1:0] stall_count_r, flush_count_r;
  logic             stall_inc_s, flush_inc_s;
  logic             lu_hazard_s, taken_s;
  logic             pc_we_s, ifid_we_s, sync_nop_s, idex_nop_s;
  logic [2:0]       sel_s;

  assign lu_hazard_s = EX_mem_read & (EX_rd != 4'd0) &
                       ((EX_rd == ID_rs) | (ID_uses_rt & (EX_rd == ID_rt)));
  assign taken_s     = bl | br | (beq & beq_equal);

  // Next-state and Mealy output decode
  always_comb begin
    next_state_s = state_r;
    fcnt_next_s  = fcnt_r;
    ctx_next_s   = ctx_r;
    stall_inc_s  = 1'b0;
    flush_inc_s  = 1'b0;
    pc_we_s      = 1'b1;
    ifid_we_s    = 1'b1;
    sync_nop_s   = 1'b0;
    idex_nop_s   = 1'b0;
    sel_s        = 3'b000;
    if (rst) begin
      next_state_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_busy) begin
            pc_we_s      = 1'b0;
            ifid_we_s    = 1'b0;
            next_state_s = FREEZE;
            ctx_next_s   = 1'b0;
          end else if (lu_hazard_s) begin
            // Any branch in ID is held and re-decoded once the bubble reaches EX
            pc_we_s     = 1'b0;
            ifid_we_s   = 1'b0;
            idex_nop_s  = 1'b1;
            stall_inc_s = 1'b1;
          end else if (taken_s) begin
            sync_nop_s  = 1'b1;
            flush_inc_s = 1'b1;
            if (bl) begin
              sel_s = 3'b001;
            end else if (br) begin
              sel_s = 3'b010;
            end else begin
              sel_s = 3'b011;
            end
            if (BRANCH_PENALTY > 1) begin
              fcnt_next_s  = FCNT_LOAD;
              next_state_s = FLUSH;
            end else begin
              next_state_s = RUN;
            end
          end else begin
            next_state_s = RUN;
          end
        end
        FLUSH: begin
          if (mem_busy) begin
            pc_we_s      = 1'b0;
            ifid_we_s    = 1'b0;
            next_state_s = FREEZE;
            ctx_next_s   = 1'b1;
          end else begin
            sync_nop_s  = 1'b1;
            fcnt_next_s = fcnt_r - 3'd1;
            if (fcnt_r == 3'd1) begin
              next_state_s = RUN;
            end else begin
              next_state_s = FLUSH;
            end
          end
        end
        FREEZE: begin
          pc_we_s   = 1'b0;
          ifid_we_s = 1'b0;
          if (!mem_busy) begin
            next_state_s = ctx_r ? FLUSH : RUN;
          end else begin
            next_state_s = FREEZE;
          end
        end
        default: begin
          next_state_s = RUN;
        end
      endcase
    end
  end

  // State, flush counter, context bit and saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RUN;
      fcnt_r        <= 3'd0;
      ctx_r         <= 1'b0;
      stall_count_r <= {CNT_W{1'b0}};
      flush_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      fcnt_r  <= fcnt_next_s;
      ctx_r   <= ctx_next_s;
      if (stall_inc_s && (stall_count_r != CNT_MAX)) begin
        stall_count_r <= stall_count_r + CNT_ONE;
      end
      if (flush_inc_s && (flush_count_r != CNT_MAX)) begin
        flush_count_r <= flush_count_r + CNT_ONE;
      end
    end
  end

  assign pc_write_en      = pc_we_s;
  assign IF_ID_write_en   = ifid_we_s;
  assign IF_ID_sync_nop   = sync_nop_s;
  assign ID_EX_nop        = idex_nop_s;
  assign IF_branch_select = sel_s;
  assign stall_count      = stall_count_r;
  assign flush_count      = flush_count_r;
  assign state_dbg        = state_r;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl: main instance with BRANCH_PENALTY=3, and a
// second instance (BRANCH_PENALTY=1, CNT_W=4) for single-cycle flush and saturation.
module tb_hazard_flush_ctrl;

  logic clk = 1'b0;
  logic rst, bl, br, beq, beq_equal, ID_uses_rt, EX_mem_read, mem_busy;
  logic [3:0] ID_rs, ID_rt, EX_rd;

  logic pc_we, ifid_we, sync_nop, idex_nop;
  logic [2:0] sel;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0] st;

  logic pc_we_s, ifid_we_s, sync_nop_s, idex_nop_s;
  logic [2:0] sel_s;
  logic [3:0] stall_cnt_s, flush_cnt_s;
  logic [1:0] st_s;

  logic [6:0] ctl, ctl_s;
  assign ctl   = {pc_we, ifid_we, sync_nop, idex_nop, sel};
  assign ctl_s = {pc_we_s, ifid_we_s, sync_nop_s, idex_nop_s, sel_s};

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  hazard_flush_ctrl #(.BRANCH_PENALTY(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bl(bl), .br(br), .beq(beq), .beq_equal(beq_equal),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt), .EX_mem_read(EX_mem_read),
    .EX_rd(EX_rd), .mem_busy(mem_busy), .pc_write_en(pc_we), .IF_ID_write_en(ifid_we),
    .IF_ID_sync_nop(sync_nop), .ID_EX_nop(idex_nop), .IF_branch_select(sel),
    .stall_count(stall_cnt), .flush_count(flush_cnt), .state_dbg(st)
  );

  hazard_flush_ctrl #(.BRANCH_PENALTY(1), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .bl(bl), .br(br), .beq(beq), .beq_equal(beq_equal),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt), .EX_mem_read(EX_mem_read),
    .EX_rd(EX_rd), .mem_busy(mem_busy), .pc_write_en(pc_we_s), .IF_ID_write_en(ifid_we_s),
    .IF_ID_sync_nop(sync_nop_s), .ID_EX_nop(idex_nop_s), .IF_branch_select(sel_s),
    .stall_count(stall_cnt_s), .flush_count(flush_cnt_s), .state_dbg(st_s)
  );

  // Advance one clock; inputs change and outputs settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bl = 1'b0; br = 1'b0; beq = 1'b0; beq_equal = 1'b0;
    ID_rs = 4'd0; ID_rt = 4'd0; ID_uses_rt = 1'b0;
    EX_mem_read = 1'b0; EX_rd = 4'd0; mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      {bl, br, beq, beq_equal, ID_uses_rt, EX_mem_read, mem_busy} = 7'($urandom);
      ID_rs = 4'($urandom); ID_rt = 4'($urandom); EX_rd = 4'($urandom);
      #4;
      total_cnt++;
      if (ctl !== 7'b1100000) $display("FAIL reset_outputs got %b exp %b", ctl, 7'b1100000);
      else pass_cnt++;
      step();
    end
    rst = 1'b0;
    idle_inputs();
    #4;
    total_cnt++;
    if ({st, stall_cnt, flush_cnt} !== {2'b00, 16'd0, 16'd0})
      $display("FAIL reset_state got st=%b stall=%0d flush=%0d exp 00/0/0", st, stall_cnt, flush_cnt);
    else pass_cnt++;
    total_cnt++;
    if (ctl !== 7'b1100000) $display("FAIL post_reset_run got %b exp %b", ctl, 7'b1100000);
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    EX_mem_read = 1'b1; EX_rd = 4'd3; ID_rs = 4'd3;
    #4;
    total_cnt++;
    if (ctl !== 7'b0001000) $display("FAIL lu_rs_stall got %b exp %b", ctl, 7'b0001000);
    else pass_cnt++;
    step();
    EX_mem_read = 1'b0;
    #4;
    total_cnt++;
    if ({ctl, stall_cnt} !== {7'b1100000, 16'd1})
      $display("FAIL lu_rs_release got %b stall=%0d exp 1100000 stall=1", ctl, stall_cnt);
    else pass_cnt++;
    step();
    EX_mem_read = 1'b1; EX_rd = 4'd0; ID_rs = 4'd0;
    #4;
    total_cnt++;
    if (ctl !== 7'b1100000) $display("FAIL lu_rd_zero got %b exp %b", ctl, 7'b1100000);
    else pass_cnt++;
    step();
    EX_rd = 4'd5; ID_rs = 4'd2; ID_rt = 4'd5; ID_uses_rt = 1'b0;
    #4;
    total_cnt++;
    if (ctl !== 7'b1100000) $display("FAIL lu_rt_unused got %b exp %b", ctl, 7'b1100000);
    else pass_cnt++;
    step();
    ID_uses_rt = 1'b1;
    #4;
    total_cnt++;
    if (ctl !== 7'b0001000) $display("FAIL lu_rt_stall got %b exp %b", ctl, 7'b0001000);
    else pass_cnt++;
    step();
    idle_inputs();
    #4;
    total_cnt++;
    if (stall_cnt !== 16'd2) $display("FAIL lu_count got %0d exp %0d", stall_cnt, 2);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    beq = 1'b1; beq_equal = 1'b1;
    #4;
    total_cnt++;
    if ({st, ctl} !== {2'b00, 7'b1110011}) $display("FAIL beq_resolve got %b/%b exp 00/1110011", st, ctl);
    else pass_cnt++;
    step();
    beq = 1'b0; beq_equal = 1'b0; bl = 1'b1;  // ignored while flushing
    #4;
    total_cnt++;
    if ({st, ctl} !== {2'b01, 7'b1110000}) $display("FAIL beq_flush1 got %b/%b exp 01/1110000", st, ctl);
    else pass_cnt++;
    step();
    #4;
    total_cnt++;
    if ({st, ctl} !== {2'b01, 7'b1110000}) $display("FAIL beq_flush2 got %b/%b exp 01/1110000", st, ctl);
    else pass_cnt++;
    step();
    bl = 1'b0; beq = 1'b1; beq_equal = 1'b0;
    #4;
    total_cnt++;
    if ({st, ctl, flush_cnt} !== {2'b00, 7'b1100000, 16'd1})
      $display("FAIL beq_done_not_taken got %b/%b flush=%0d exp 00/1100000 flush=1", st, ctl, flush_cnt);
    else pass_cnt++;
    step();
    beq = 1'b0; br = 1'b1;
    #4;
    total_cnt++;
    if (ctl !== 7'b1110010) $display("FAIL br_select got %b exp %b", ctl, 7'b1110010);
    else pass_cnt++;
    step(); br = 1'b0; step(); step();
    bl = 1'b1; br = 1'b1; beq = 1'b1; beq_equal = 1'b1;
    #4;
    total_cnt++;
    if (ctl !== 7'b1110001) $display("FAIL bl_over_br_beq got %b exp %b", ctl, 7'b1110001);
    else pass_cnt++;
    step(); idle_inputs(); step(); step();
    #4;
    total_cnt++;
    if ({st, flush_cnt} !== {2'b00, 16'd3}) $display("FAIL branch_count got st=%b flush=%0d exp 00/3", st, flush_cnt);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    bl = 1'b1; EX_mem_read = 1'b1; EX_rd = 4'd7; ID_rs = 4'd7;
    #4;
    total_cnt++;
    if (ctl !== 7'b0001000) $display("FAIL lu_over_bl got %b exp %b", ctl, 7'b0001000);
    else pass_cnt++;
    step();
    EX_mem_read = 1'b0;
    #4;
    total_cnt++;
    if ({ctl, stall_cnt} !== {7'b1110001, 16'd3})
      $display("FAIL bl_deferred got %b stall=%0d exp 1110001 stall=3", ctl, stall_cnt);
    else pass_cnt++;
    step(); idle_inputs(); step(); step();
    EX_mem_read = 1'b1; EX_rd = 4'd4; ID_rs = 4'd4; mem_busy = 1'b1;
    #4;
    total_cnt++;
    if (ctl !== 7'b0000000) $display("FAIL busy_over_lu got %b exp %b", ctl, 7'b0000000);
    else pass_cnt++;
    step();
    idle_inputs();
    #4;
    total_cnt++;
    if ({st, ctl, stall_cnt} !== {2'b10, 7'b0000000, 16'd3})
      $display("FAIL freeze_release got %b/%b stall=%0d exp 10/0000000 stall=3", st, ctl, stall_cnt);
    else pass_cnt++;
    step();
    #4;
    total_cnt++;
    if ({st, ctl} !== {2'b00, 7'b1100000}) $display("FAIL freeze_to_run got %b/%b exp 00/1100000", st, ctl);
    else pass_cnt++;
  endtask

  task automatic test_freeze_mid_flush();
    beq = 1'b1; beq_equal = 1'b1;
    step();
    idle_inputs();
    step();
    mem_busy = 1'b1;  // last flush cycle, counter=1
    for (int i = 0; i < 4; i++) begin
      #4;
      total_cnt++;
      if ({st, ctl} !== {(i == 0) ? 2'b01 : 2'b10, 7'b0000000})
        $display("FAIL mid_flush_busy%0d got %b/%b exp %b/0000000", i, st, ctl, (i == 0) ? 2'b01 : 2'b10);
      else pass_cnt++;
      step();
    end
    mem_busy = 1'b0;
    #4;
    total_cnt++;
    if ({st, ctl} !== {2'b10, 7'b0000000}) $display("FAIL mid_flush_release got %b/%b exp 10/0000000", st, ctl);
    else pass_cnt++;
    step();
    #4;
    total_cnt++;
    if ({st, ctl} !== {2'b01, 7'b1110000}) $display("FAIL mid_flush_resume got %b/%b exp 01/1110000", st, ctl);
    else pass_cnt++;
    step();
    #4;
    total_cnt++;
    if ({st, ctl, flush_cnt} !== {2'b00, 7'b1100000, 16'd5})
      $display("FAIL mid_flush_done got %b/%b flush=%0d exp 00/1100000 flush=5", st, ctl, flush_cnt);
    else pass_cnt++;
  endtask

  task automatic test_penalty_one();
    beq = 1'b1; beq_equal = 1'b1;
    #4;
    total_cnt++;
    if (ctl_s !== 7'b1110011) $display("FAIL p1_resolve got %b exp %b", ctl_s, 7'b1110011);
    else pass_cnt++;
    step();
    idle_inputs();
    #4;
    total_cnt++;
    if ({st_s, ctl_s} !== {2'b00, 7'b1100000}) $display("FAIL p1_single_nop got %b/%b exp 00/1100000", st_s, ctl_s);
    else pass_cnt++;
    step(); step();
  endtask

  task automatic test_saturation();
    EX_mem_read = 1'b1; EX_rd = 4'd9; ID_rs = 4'd9;
    for (int i = 0; i < 20; i++) step();
    idle_inputs();
    #4;
    total_cnt++;
    if (stall_cnt_s !== 4'd15) $display("FAIL sat_stall4 got %0d exp %0d", stall_cnt_s, 15);
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 16'd23) $display("FAIL stall16_after_20 got %0d exp %0d", stall_cnt, 23);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_flush();
    beq = 1'b1; beq_equal = 1'b1;
    step();
    idle_inputs();
    rst = 1'b1;
    #4;
    total_cnt++;
    if (ctl !== 7'b1100000) $display("FAIL rst_mid_flush_out got %b exp %b", ctl, 7'b1100000);
    else pass_cnt++;
    step();
    rst = 1'b0;
    #4;
    total_cnt++;
    if ({st, ctl, stall_cnt, flush_cnt} !== {2'b00, 7'b1100000, 16'd0, 16'd0})
      $display("FAIL rst_mid_flush_state got %b/%b stall=%0d flush=%0d exp 00/1100000/0/0", st, ctl, stall_cnt, flush_cnt);
    else pass_cnt++;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    step();
    test_load_use();
    step();
    test_branch();
    step();
    test_priority();
    step();
    test_freeze_mid_flush();
    step();
    test_penalty_one();
    test_saturation();
    step();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Central pipeline sequencing controller for the 16-bit CPU. It sits between the ID-stage decode/compare logic and the IF/ID, ID/EX and PC write enables.
- Resolves three hazard classes with fixed priority: memory-busy freeze, load-use stall, and taken-branch flush.
- Drives the next-PC mux select and the pipeline bubble controls.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- BRANCH_PENALTY, 1: IF_ID_sync_nop cycles per taken branch, including the resolve cycle; legal range 1-7.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- bl  input  1  ID holds branch-and-link
- br  input  1  ID holds branch-register
- beq  input  1  ID holds branch-if-equal
- beq_equal  input  1  forwarded ID compare result, operands equal
- ID_rs  input  4  ID source register 1
- ID_rt  input  4  ID source register 2
- ID_uses_rt  input  1  ID instruction reads rt
- EX_mem_read  input  1  EX holds a load
- EX_rd  input  4  EX destination register
- mem_busy  input  1  data memory not ready; freeze the whole pipeline
- pc_write_en  output  1  PC update enable
- IF_ID_write_en  output  1  IF/ID latch enable
- IF_ID_sync_nop  output  1  replace IF/ID contents with NOP on next edge
- ID_EX_nop  output  1  insert bubble into ID/EX on next edge
- IF_branch_select  output  3  next-PC select: 000 PC+1, 001 bl target, 010 br register target, 011 beq target, others reserved (never driven)
- stall_count  output  CNT_W  load-use stall cycles, saturating
- flush_count  output  CNT_W  taken branches, saturating
- state_dbg  output  2  current FSM state

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset response: state=RUN, flush counter=0, stall_count=0, flush_count=0.
  - Outputs during reset cycle: pc_write_en=1, IF_ID_write_en=1, IF_ID_sync_nop=0, ID_EX_nop=0, IF_branch_select=000.
  - rst mid-flush or mid-freeze abandons the operation immediately; the counters clear.
- Combinational terms:
  - lu_hazard = EX_mem_read & (EX_rd!=0) & ((EX_rd==ID_rs) | (ID_uses_rt & EX_rd==ID_rt))
  - taken = bl | br | (beq & beq_equal)
- States: RUN=00, FLUSH=01, FREEZE=10. Encoding 11 is unreachable and must recover to RUN on the next edge.
- Outputs are Mealy, valid in the same cycle as the inputs.
- RUN, priority mem_busy > lu_hazard > taken:
  - mem_busy:
    - pc_write_en=0, IF_ID_write_en=0, ID_EX_nop=0.
    - Next state FREEZE. Saved context bit = 0 (came from RUN).
  - lu_hazard:
    - pc_write_en=0, IF_ID_write_en=0, ID_EX_nop=1. Stay in RUN.
    - stall_count increments. The hazard clears next cycle because EX then holds a bubble.
    - A branch in ID is deferred, not lost; it re-evaluates next cycle.
  - taken:
    - IF_ID_sync_nop=1; IF_branch_select = 001 for bl, 010 for br, 011 for beq. If several are asserted, bl > br > beq.
    - pc_write_en=1. flush_count increments.
    - If BRANCH_PENALTY>1: load flush counter with BRANCH_PENALTY-1, next state FLUSH. Otherwise stay in RUN.
  - Otherwise: all enables 1, nops 0, select 000.
  - beq with beq_equal=0 is not taken: no nop, select 000.
- FLUSH:
  - IF_ID_sync_nop=1, select 000, PC advances. Counter decrements each cycle.
  - Return to RUN when the counter reaches 1 and decrements.
  - Branch inputs are ignored in this state; ID holds a nop.
  - mem_busy in FLUSH: freeze with the counter held. Next state FREEZE, saved context bit = 1 (came from FLUSH).
- FREEZE:
  - pc_write_en=0, IF_ID_write_en=0, all nops 0, select 000.
  - Stay while mem_busy=1.
  - On mem_busy=0: return to FLUSH if the saved context bit is 1, else RUN. Evaluate RUN logic the following cycle; there is no same-cycle re-decision.
- Counters saturate at all-ones and never wrap.
- A simultaneous lu_hazard and taken increments only stall_count.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> state_dbg=00, both counts=0, pc_write_en=1, select=000.
- Load-use: EX_mem_read=1, EX_rd=3, ID_rs=3 for one cycle, then EX_mem_read=0 -> exactly one cycle of pc_write_en=0, IF_ID_write_en=0, ID_EX_nop=1; stall_count=1. The EX_rd=0 variant -> no stall.
- Branch, BRANCH_PENALTY=3: beq=1, beq_equal=1 -> select=011, IF_ID_sync_nop high for 3 consecutive cycles, state 00→01→01→00, flush_count=1. The beq_equal=0 variant -> no nop.
- Priority: bl=1 with lu_hazard=1 -> stall first (select=000); the next cycle with hazard cleared gives select=001 and a nop.
- Freeze mid-flush (PENALTY=3): mem_busy=1 for 4 cycles on flush cycle 2 -> enables low for 4 cycles, counter held, then the remaining nop cycle, then RUN.
- Saturation (CNT_W=4): 20 load-use stalls -> stall_count=15.
